// File: rtl/hazard_forward_unit_pkg.sv
// Shared pipeline definitions for the hazard/forwarding unit:
// operand-mux select encodings, the stall sequencer state type and
// the default register-address width.
package hazard_forward_unit_pkg;

    // Default register-address width (32-entry register file)
    localparam int REG_AW_DEFAULT = 5;

    // EX operand mux select encodings; 2'b11 is never driven
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Stall sequencer states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } stall_state_e;

endpackage : hazard_forward_unit_pkg

// File: rtl/hazard_forward_unit_fwd_select.sv
// Per-operand forwarding priority comparator. Picks the youngest
// in-flight producer of the EX-stage source register; the younger
// EX/MEM result always beats the older MEM/WB result. Register 0 is
// hard-wired zero, so a producer targeting it is never a match.
module fwd_select
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic              exmem_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              memwb_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    output logic [1:0]        sel_o
);

    logic exmemHit;
    logic memwbHit;

    assign exmemHit = exmem_write_i && (exmem_rd_i != '0) && (exmem_rd_i == src_i);
    assign memwbHit = memwb_write_i && (memwb_rd_i != '0) && (memwb_rd_i == src_i);

    // Priority select: EX/MEM first, then MEM/WB, otherwise the register file
    always_comb begin
        sel_o = FWD_RF;
        if (exmemHit) begin
            sel_o = FWD_EXMEM;
        end else if (memwbHit) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule : fwd_select

// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding plus load-use hazard detection with a
// stall sequencer. A load whose destination is read by the decode
// instruction holds PC/IF-ID and injects LOAD_LAT bubbles into ID/EX.
// An external hold freezes the sequencer without consuming stall
// cycles. A saturating counter tallies the stall cycles actually spent.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEFAULT,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] IFID_Rs,
    input  logic [REG_AW-1:0] IFID_Rt,
    input  logic              IFID_uses_rt,
    input  logic [REG_AW-1:0] IDEX_Rs,
    input  logic [REG_AW-1:0] IDEX_Rt,
    input  logic [REG_AW-1:0] IDEX_Rd,
    input  logic              IDEX_mem_read,
    input  logic              EXMEM_reg_write,
    input  logic [REG_AW-1:0] EXMEM_Rd,
    input  logic              MEMWB_reg_write,
    input  logic [REG_AW-1:0] MEMWB_Rd,
    input  logic              hold,
    output logic [1:0]        forwardA,
    output logic [1:0]        forwardB,
    output logic              stall,
    output logic              bubble,
    output logic [CNT_W-1:0]  stall_cycles
);

    // Width of the remaining-bubble down-counter
    localparam int REM_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT + 1) : 1;

    stall_state_e     state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic haz;
    logic stallComb;
    logic bubbleComb;

    // Operand A and B forwarding, purely combinational and reset-independent
    fwd_select #(.REG_AW(REG_AW)) u_fwdA (
        .src_i         (IDEX_Rs),
        .exmem_write_i (EXMEM_reg_write),
        .exmem_rd_i    (EXMEM_Rd),
        .memwb_write_i (MEMWB_reg_write),
        .memwb_rd_i    (MEMWB_Rd),
        .sel_o         (forwardA)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwdB (
        .src_i         (IDEX_Rt),
        .exmem_write_i (EXMEM_reg_write),
        .exmem_rd_i    (EXMEM_Rd),
        .memwb_write_i (MEMWB_reg_write),
        .memwb_rd_i    (MEMWB_Rd),
        .sel_o         (forwardB)
    );

    // Load-use hazard: Rt only matters when decode really reads it
    assign haz = IDEX_mem_read && (IDEX_Rd != '0) &&
                 ((IDEX_Rd == IFID_Rs) || (IFID_uses_rt && (IDEX_Rd == IFID_Rt)));

    // Sequencer next-state and stall/bubble decode. The first bubble is
    // issued from IDLE, so STALL only covers the remaining LOAD_LAT-1.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        stallComb  = 1'b0;
        bubbleComb = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stallComb  = haz && !hold;
                bubbleComb = haz && !hold;
                if (haz && !hold && (LOAD_LAT > 1)) begin
                    state_d = ST_STALL;
                    rem_d   = REM_W'(LOAD_LAT - 1);
                end
            end
            ST_STALL: begin
                stallComb  = 1'b1;
                bubbleComb = !hold;
                if (!hold) begin
                    if (rem_q <= REM_W'(1)) begin
                        state_d = ST_IDLE;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - REM_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
        endcase
    end

    // Saturating stall-cycle counter: only non-hold stall cycles count
    always_comb begin
        cnt_d = cnt_q;
        if (stallComb && !hold && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, remaining-bubble and counter registers with async reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset squashes pipeline control immediately, independent of the clock
    assign stall        = rst ? 1'b0 : stallComb;
    assign bubble       = rst ? 1'b0 : bubbleComb;
    assign stall_cycles = cnt_q;

endmodule : hazard_forward_unit

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: three instances with different load
// latencies and counter widths share one stimulus stream. A reference
// model tracks, per instance, how many stall cycles a hazard still owes
// and the saturating stall total, and every cycle is compared against it.
module tb_hazard_forward_unit;

    localparam int AW   = 5;
    localparam int NDUT = 3;

    logic          clk;
    logic          rst;
    logic [AW-1:0] IFID_Rs, IFID_Rt, IDEX_Rs, IDEX_Rt, IDEX_Rd, EXMEM_Rd, MEMWB_Rd;
    logic          IFID_uses_rt, IDEX_mem_read, EXMEM_reg_write, MEMWB_reg_write, hold;

    logic [1:0]    faO     [NDUT];
    logic [1:0]    fbO     [NDUT];
    logic          stallO  [NDUT];
    logic          bubbleO [NDUT];
    logic [15:0]   cnt1, cnt3;
    logic [3:0]    cnt4;

    int compared;
    int mismatched;
    int remM [NDUT];
    int cntM [NDUT];
    int stallSum;
    int bubbleSum;

    hazard_forward_unit #(.REG_AW(AW), .LOAD_LAT(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_uses_rt(IFID_uses_rt),
        .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt), .IDEX_Rd(IDEX_Rd), .IDEX_mem_read(IDEX_mem_read),
        .EXMEM_reg_write(EXMEM_reg_write), .EXMEM_Rd(EXMEM_Rd), .MEMWB_reg_write(MEMWB_reg_write),
        .MEMWB_Rd(MEMWB_Rd), .hold(hold), .forwardA(faO[0]), .forwardB(fbO[0]),
        .stall(stallO[0]), .bubble(bubbleO[0]), .stall_cycles(cnt1)
    );

    hazard_forward_unit #(.REG_AW(AW), .LOAD_LAT(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_uses_rt(IFID_uses_rt),
        .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt), .IDEX_Rd(IDEX_Rd), .IDEX_mem_read(IDEX_mem_read),
        .EXMEM_reg_write(EXMEM_reg_write), .EXMEM_Rd(EXMEM_Rd), .MEMWB_reg_write(MEMWB_reg_write),
        .MEMWB_Rd(MEMWB_Rd), .hold(hold), .forwardA(faO[1]), .forwardB(fbO[1]),
        .stall(stallO[1]), .bubble(bubbleO[1]), .stall_cycles(cnt3)
    );

    hazard_forward_unit #(.REG_AW(AW), .LOAD_LAT(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_uses_rt(IFID_uses_rt),
        .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt), .IDEX_Rd(IDEX_Rd), .IDEX_mem_read(IDEX_mem_read),
        .EXMEM_reg_write(EXMEM_reg_write), .EXMEM_Rd(EXMEM_Rd), .MEMWB_reg_write(MEMWB_reg_write),
        .MEMWB_Rd(MEMWB_Rd), .hold(hold), .forwardA(faO[2]), .forwardB(fbO[2]),
        .stall(stallO[2]), .bubble(bubbleO[2]), .stall_cycles(cnt4)
    );

    // Free-running pipeline clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int latOf(int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    function automatic int cmaxOf(int i);
        return (i == 2) ? 15 : 65535;
    endfunction

    function automatic logic [31:0] cntObs(int i);
        if (i == 0) return 32'(cnt1);
        if (i == 1) return 32'(cnt3);
        return 32'(cnt4);
    endfunction

    // Youngest writer of a nonzero register wins; else the register file
    function automatic logic [1:0] fwdRef(logic [AW-1:0] src);
        if (EXMEM_reg_write && EXMEM_Rd != 0 && EXMEM_Rd == src) return 2'b10;
        if (MEMWB_reg_write && MEMWB_Rd != 0 && MEMWB_Rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit hazRef();
        return IDEX_mem_read && IDEX_Rd != 0 &&
               (IDEX_Rd == IFID_Rs || (IFID_uses_rt && IDEX_Rd == IFID_Rt));
    endfunction

    function automatic bit expStall(int i);
        if (rst) return 1'b0;
        if (remM[i] > 0) return 1'b1;
        return hazRef() && !hold;
    endfunction

    function automatic bit expBubble(int i);
        if (rst) return 1'b0;
        if (remM[i] > 0) return !hold;
        return hazRef() && !hold;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("%s.fwdA%0d", tag, i), 32'(faO[i]), 32'(fwdRef(IDEX_Rs)));
            checkOutput($sformatf("%s.fwdB%0d", tag, i), 32'(fbO[i]), 32'(fwdRef(IDEX_Rt)));
            checkOutput($sformatf("%s.stall%0d", tag, i), 32'(stallO[i]), 32'(expStall(i)));
            checkOutput($sformatf("%s.bubble%0d", tag, i), 32'(bubbleO[i]), 32'(expBubble(i)));
            checkOutput($sformatf("%s.cnt%0d", tag, i), cntObs(i), 32'(cntM[i]));
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NDUT; i++) begin
            remM[i] = 0;
            cntM[i] = 0;
        end
    endtask

    // Advance the model by one clock using the pre-edge inputs
    task automatic modelStep();
        bit st;
        if (!rst) begin
            for (int i = 0; i < NDUT; i++) begin
                st = expStall(i);
                if (st && !hold && cntM[i] < cmaxOf(i)) cntM[i]++;
                if (remM[i] > 0) begin
                    if (!hold) remM[i]--;
                end else if (hazRef() && !hold) begin
                    remM[i] = latOf(i) - 1;
                end
            end
        end
    endtask

    // One cycle: settle, compare everything, clock, advance the model
    task automatic cycleCheck(input string tag);
        #1;
        checkAll(tag);
        stallSum  += int'(stallO[1]);
        bubbleSum += int'(bubbleO[1]);
        @(posedge clk);
        modelStep();
        #2;
    endtask

    task automatic applyStimulus(input logic memRead, input logic [AW-1:0] rd,
                                 input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                 input logic usesRt, input logic holdV);
        IDEX_mem_read = memRead;
        IDEX_Rd       = rd;
        IFID_Rs       = rs;
        IFID_Rt       = rt;
        IFID_uses_rt  = usesRt;
        hold          = holdV;
    endtask

    task automatic doReset();
        rst = 1'b1;
        modelReset();
        cycleCheck("reset");
        rst = 1'b0;
    endtask

    initial begin
        compared        = 0;
        mismatched      = 0;
        stallSum        = 0;
        bubbleSum       = 0;
        rst             = 1'b1;
        EXMEM_reg_write = 1'b0;
        EXMEM_Rd        = '0;
        MEMWB_reg_write = 1'b0;
        MEMWB_Rd        = '0;
        IDEX_Rs         = '0;
        IDEX_Rt         = '0;
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        modelReset();
        @(posedge clk);
        #2;
        doReset();
        checkOutput("reset_cnt1", 32'(cnt1), 32'd0);

        // Forwarding priority: EX/MEM beats MEM/WB on the same register
        EXMEM_reg_write = 1'b1; EXMEM_Rd = 5'd3;
        MEMWB_reg_write = 1'b1; MEMWB_Rd = 5'd3;
        IDEX_Rs = 5'd3; IDEX_Rt = 5'd4;
        #1;
        checkOutput("fwdA_exmem_wins", 32'(faO[0]), 32'h2);
        checkOutput("fwdB_regfile", 32'(fbO[0]), 32'h0);
        cycleCheck("fwd_prio");
        EXMEM_reg_write = 1'b0;
        #1;
        checkOutput("fwdA_memwb", 32'(faO[0]), 32'h1);
        cycleCheck("fwd_memwb");

        // Register zero is never forwarded
        MEMWB_reg_write = 1'b1; MEMWB_Rd = 5'd0; IDEX_Rs = 5'd0;
        #1;
        checkOutput("fwdA_zero_memwb", 32'(faO[0]), 32'h0);
        cycleCheck("fwd_zero1");
        EXMEM_reg_write = 1'b1; EXMEM_Rd = 5'd0;
        #1;
        checkOutput("fwdA_zero_exmem", 32'(faO[0]), 32'h0);
        cycleCheck("fwd_zero2");

        // Single-bubble load-use on the LOAD_LAT=1 instance
        doReset();
        applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        #1;
        checkOutput("ll1_stall", 32'(stallO[0]), 32'h1);
        checkOutput("ll1_bubble", 32'(bubbleO[0]), 32'h1);
        cycleCheck("ll1_haz");
        applyStimulus(1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        #1;
        checkOutput("ll1_stall_done", 32'(stallO[0]), 32'h0);
        checkOutput("ll1_cnt", 32'(cnt1), 32'd1);
        cycleCheck("ll1_after");
        applyStimulus(1'b1, 5'd5, 5'd6, 5'd5, 1'b0, 1'b0);
        #1;
        checkOutput("ll1_rt_unused", 32'(stallO[0]), 32'h0);
        cycleCheck("ll1_rt");
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycleCheck("ll1_drain");

        // LOAD_LAT=3 with a hold on the second stall cycle
        doReset();
        stallSum  = 0;
        bubbleSum = 0;
        applyStimulus(1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0);
        cycleCheck("ll3_c1");
        applyStimulus(1'b0, 5'd7, 5'd2, 5'd7, 1'b1, 1'b1);
        cycleCheck("ll3_c2_hold");
        applyStimulus(1'b0, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) cycleCheck("ll3_rest");
        checkOutput("ll3_stall_cycles_seen", 32'(stallSum), 32'd4);
        checkOutput("ll3_bubble_cycles_seen", 32'(bubbleSum), 32'd3);
        checkOutput("ll3_cnt", 32'(cnt3), 32'd3);
        #1;
        checkOutput("ll3_idle", 32'(stallO[1]), 32'h0);
        cycleCheck("ll3_idle_cyc");

        // Continuous hazards: the 4-bit counter saturates, 16-bit ones keep counting
        doReset();
        applyStimulus(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) cycleCheck("sat");
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        checkOutput("sat_cnt4", 32'(cnt4), 32'd15);
        checkOutput("sat_cnt1", 32'(cnt1), 32'd20);
        checkOutput("sat_cnt3", 32'(cnt3), 32'd20);
        cycleCheck("sat_after");
        for (int k = 0; k < 4; k++) cycleCheck("sat_drain");

        // Asynchronous reset mid-sequence on the LOAD_LAT=4 instance
        doReset();
        applyStimulus(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
        cycleCheck("arst_c1");
        applyStimulus(1'b0, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
        EXMEM_reg_write = 1'b1; EXMEM_Rd = 5'd3; IDEX_Rs = 5'd3;
        #1;
        checkOutput("arst_pre_stall", 32'(stallO[2]), 32'h1);
        checkAll("arst_pre");
        #1;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("arst_stall", 32'(stallO[2]), 32'h0);
        checkOutput("arst_bubble", 32'(bubbleO[2]), 32'h0);
        checkOutput("arst_cnt", 32'(cnt4), 32'd0);
        checkOutput("arst_fwdA", 32'(faO[2]), 32'h2);
        checkAll("arst_in");
        #1;
        rst = 1'b0;
        @(posedge clk);
        modelStep();
        #2;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("arst_post_stall", 32'(stallO[2]), 32'h0);
            #1;
            cycleCheck("arst_post");
        end

        // Randomized traffic over a small register range to force collisions
        doReset();
        for (int k = 0; k < 400; k++) begin
            rst             = ($urandom_range(0, 99) < 2);
            IFID_Rs         = AW'($urandom_range(0, 3));
            IFID_Rt         = AW'($urandom_range(0, 3));
            IFID_uses_rt    = 1'($urandom_range(0, 1));
            IDEX_Rs         = AW'($urandom_range(0, 3));
            IDEX_Rt         = AW'($urandom_range(0, 3));
            IDEX_Rd         = AW'($urandom_range(0, 3));
            IDEX_mem_read   = ($urandom_range(0, 99) < 60);
            EXMEM_reg_write = 1'($urandom_range(0, 1));
            EXMEM_Rd        = AW'($urandom_range(0, 3));
            MEMWB_reg_write = 1'($urandom_range(0, 1));
            MEMWB_Rd        = AW'($urandom_range(0, 3));
            hold            = ($urandom_range(0, 99) < 20);
            if (rst) modelReset();
            cycleCheck("rand");
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_hazard_forward_unit
